// File: rtl/program_data_mem.sv
// -----------------------------------------------------------------------------
// program_data_mem
//
// Instruction memory and data memory for a small CPU, each DEPTH x 32,
// byte-writable and read-first. A boot loader fills both memories while the
// block is in LOAD. Fetch and CPU data traffic is served in RUN.
//
// Parameters
//   DEPTH          words per memory (power of two, 1024..65536)
//   READ_LATENCY   cycles from accepted request to response (1 or 2)
//   BOOT_ON_RESET  1: leave reset in LOAD, 0: leave reset in RUN
//   MIRROR_STORES  1: accepted CPU stores also update instruction memory
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   pc_in, fetch_req_in       instruction fetch request
//   instr_out, instr_valid_out, instr_fault_out
//                             fetch response (pulses READ_LATENCY later)
//   cpu_addr_in, cpu_data_in, cpu_write_enable_in (byte mask), cpu_read_in
//                             CPU data request
//   cpu_data_out, cpu_data_valid_out, cpu_fault_out
//                             CPU response (pre-write word, READ_LATENCY later)
//   brx_addr_in, brx_data_in, brx_valid_in, brx_done_in
//                             boot loader word stream and completion strobe
//   cpu_stall_out             requests are ignored while high
//   boot_busy_out             high in LOAD
//   boot_word_count_out       loader words accepted since boot/reload
// -----------------------------------------------------------------------------
module program_data_mem #(
  parameter int DEPTH         = 16384,
  parameter int READ_LATENCY  = 2,
  parameter int BOOT_ON_RESET = 1,
  parameter int MIRROR_STORES = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  // fetch
  input  logic [31:0] pc_in,
  input  logic        fetch_req_in,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        instr_fault_out,
  // cpu data
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_write_enable_in,
  input  logic        cpu_read_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_data_valid_out,
  output logic        cpu_fault_out,
  // boot loader
  input  logic [31:0] brx_addr_in,
  input  logic [31:0] brx_data_in,
  input  logic        brx_valid_in,
  input  logic        brx_done_in,
  // status
  output logic        cpu_stall_out,
  output logic        boot_busy_out,
  output logic [15:0] boot_word_count_out
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = (BOOT_ON_RESET != 0) ? ST_LOAD : ST_RUN;

  // An address is in range iff addr < 4*DEPTH, i.e. nothing set above the
  // word index bits.
  function automatic logic in_range(input logic [31:0] addr);
    return addr[31:AW+2] == '0;
  endfunction

  // Word alignment of CPU and loader addresses is not enforced; the low bits
  // are intentionally ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{cpu_addr_in[1:0], brx_addr_in[1:0]};

  // ---------------------------------------------------------------------------
  // Control: state, stall, request acceptance
  // ---------------------------------------------------------------------------
  logic [0:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic        stall;
  logic        ld_in_range, ld_we;
  logic        fetch_acc, fetch_fault;
  logic        cpu_acc, cpu_in_range;
  logic [3:0]  cpu_we;

  assign stall        = (state_q == ST_LOAD) | brx_valid_in;
  assign ld_in_range  = in_range(brx_addr_in);
  // A loader word is written in LOAD and also on the RUN cycle that triggers
  // a hot reload, so no state qualifier is needed here.
  assign ld_we        = brx_valid_in & ld_in_range;

  assign fetch_acc    = fetch_req_in & ~stall;
  assign fetch_fault  = ~in_range(pc_in) | (pc_in[1:0] != 2'b00);

  assign cpu_acc      = (cpu_read_in | (|cpu_write_enable_in)) & ~stall;
  assign cpu_in_range = in_range(cpu_addr_in);
  assign cpu_we       = (cpu_acc & cpu_in_range) ? cpu_write_enable_in : 4'h0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_LOAD) begin
      if (ld_we && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (brx_done_in)                state_d = ST_RUN;
    end else if (brx_valid_in) begin
      state_d = ST_LOAD;
      cnt_d   = ld_in_range ? 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst_in) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_stall_out       = stall;
  assign boot_busy_out       = (state_q == ST_LOAD);
  assign boot_word_count_out = cnt_q;

  // ---------------------------------------------------------------------------
  // Memories. Loader writes only happen while stalled and CPU writes only
  // while not stalled, so one write port per memory is enough.
  // ---------------------------------------------------------------------------
  logic [31:0]   imem [DEPTH];
  logic [31:0]   dmem [DEPTH];
  logic [31:0]   imem_rd_q, dmem_rd_q;

  logic [3:0]    dmem_we, imem_we;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [AW-1:0] pc_idx, cpu_idx;

  assign pc_idx  = pc_in[AW+1:2];
  assign cpu_idx = cpu_addr_in[AW+1:2];
  assign wr_idx  = ld_we ? brx_addr_in[AW+1:2] : cpu_idx;
  assign wr_data = ld_we ? brx_data_in : cpu_data_in;
  assign dmem_we = ld_we ? 4'hF : cpu_we;
  assign imem_we = ld_we ? 4'hF : ((MIRROR_STORES != 0) ? cpu_we : 4'h0);

  // NOTE: memory arrays and their read registers have no reset; contents
  // must survive reset, and a reset term would prevent RAM inference.
  // Reading and writing in one block with <= gives read-first behaviour.
  always_ff @(posedge clk_in) begin
    for (int b = 0; b < 4; b++) begin
      if (imem_we[b]) imem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      if (dmem_we[b]) dmem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
    imem_rd_q <= imem[pc_idx];
    dmem_rd_q <= dmem[cpu_idx];
  end

  // ---------------------------------------------------------------------------
  // Response pipelines. Stage 1 tracks valid/fault alongside the RAM read;
  // faulted or idle responses force the data to zero.
  // ---------------------------------------------------------------------------
  logic        f1_valid_q, f1_fault_q;
  logic        c1_valid_q, c1_fault_q;
  logic [31:0] f1_data, c1_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      f1_valid_q <= 1'b0;
      f1_fault_q <= 1'b0;
      c1_valid_q <= 1'b0;
      c1_fault_q <= 1'b0;
    end else begin
      f1_valid_q <= fetch_acc;
      f1_fault_q <= fetch_acc & fetch_fault;
      c1_valid_q <= cpu_acc;
      c1_fault_q <= cpu_acc & ~cpu_in_range;
    end
  end

  assign f1_data = (f1_valid_q && !f1_fault_q) ? imem_rd_q : 32'h0;
  assign c1_data = (c1_valid_q && !c1_fault_q) ? dmem_rd_q : 32'h0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic        f2_valid_q, f2_fault_q, c2_valid_q, c2_fault_q;
    logic [31:0] f2_data_q, c2_data_q;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        f2_valid_q <= 1'b0;
        f2_fault_q <= 1'b0;
        f2_data_q  <= '0;
        c2_valid_q <= 1'b0;
        c2_fault_q <= 1'b0;
        c2_data_q  <= '0;
      end else begin
        f2_valid_q <= f1_valid_q;
        f2_fault_q <= f1_fault_q;
        f2_data_q  <= f1_data;
        c2_valid_q <= c1_valid_q;
        c2_fault_q <= c1_fault_q;
        c2_data_q  <= c1_data;
      end
    end

    assign instr_valid_out    = f2_valid_q;
    assign instr_fault_out    = f2_fault_q;
    assign instr_out          = f2_data_q;
    assign cpu_data_valid_out = c2_valid_q;
    assign cpu_fault_out      = c2_fault_q;
    assign cpu_data_out       = c2_data_q;
  end else begin : g_lat1
    assign instr_valid_out    = f1_valid_q;
    assign instr_fault_out    = f1_fault_q;
    assign instr_out          = f1_data;
    assign cpu_data_valid_out = c1_valid_q;
    assign cpu_fault_out      = c1_fault_q;
    assign cpu_data_out       = c1_data;
  end

endmodule
